// File: rtl/coin_sched_if.sv
// Coin scheduler bus: acceptor pulses, core coin outputs, FIFO status.
// Statistics counters are present only when COIN_SCHED_STATS_EN is defined.
interface coin_sched_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                     a_nickel;
  logic                     a_dime;
  logic                     a_quarter;
  logic                     b_nickel;
  logic                     b_dime;
  logic                     b_quarter;
  logic                     vend_busy;
  logic                     nickel;
  logic                     dime;
  logic                     quarter;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     fifo_full;
  logic                     coin_drop;
`ifdef COIN_SCHED_STATS_EN
  logic [CNT_W-1:0]         soda_count;
  logic [CNT_W-1:0]         drop_count;

  modport master (
    output a_nickel, a_dime, a_quarter, b_nickel, b_dime, b_quarter, vend_busy,
    input  nickel, dime, quarter, fifo_level, fifo_full, coin_drop,
           soda_count, drop_count
  );

  modport slave (
    input  a_nickel, a_dime, a_quarter, b_nickel, b_dime, b_quarter, vend_busy,
    output nickel, dime, quarter, fifo_level, fifo_full, coin_drop,
           soda_count, drop_count
  );
`else
  modport master (
    output a_nickel, a_dime, a_quarter, b_nickel, b_dime, b_quarter, vend_busy,
    input  nickel, dime, quarter, fifo_level, fifo_full, coin_drop
  );

  modport slave (
    input  a_nickel, a_dime, a_quarter, b_nickel, b_dime, b_quarter, vend_busy,
    output nickel, dime, quarter, fifo_level, fifo_full, coin_drop
  );
`endif

  if (DEPTH < 2 || CNT_W < 1) begin : g_param_check
    $error("coin_sched_if: DEPTH must be >= 2 and CNT_W >= 1");
  end
endinterface

// File: rtl/coin_sched.sv
// Coin front-end scheduler: merges two coin acceptors into a small FIFO and
// feeds the vending core one registered one-hot coin at a time, never in two
// consecutive cycles and never while the core is dispensing.
// Optional statistics counters are enabled by defining COIN_SCHED_STATS_EN.
module coin_sched #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  coin_sched_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {PRI_A, PRI_B} pri_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
    $error("coin_sched: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] space;
  pri_t          pri;
  logic          out_n;
  logic          out_d;
  logic          out_q;
  logic          drop_q;

  logic [2:0]    a_bits;
  logic [2:0]    b_bits;
  logic          a_valid;
  logic          b_valid;
  logic          a_bad;
  logic          b_bad;
  logic [1:0]    a_code;
  logic [1:0]    b_code;
  logic [1:0]    first_code;
  logic [1:0]    second_code;
  logic [1:0]    n_valid;
  logic [1:0]    n_drop;
  logic          wr0;
  logic          wr1;
  logic          pop;
  logic [1:0]    head;

  // Classify port events, order simultaneous coins by priority, decide writes, drops and pop.
  always_comb begin
    a_bits      = {bus.a_quarter, bus.a_dime, bus.a_nickel};
    b_bits      = {bus.b_quarter, bus.b_dime, bus.b_nickel};
    a_valid     = $onehot(a_bits);
    b_valid     = $onehot(b_bits);
    a_bad       = (a_bits != 3'b000) && !a_valid;
    b_bad       = (b_bits != 3'b000) && !b_valid;
    // one-hot {q,d,n} -> 2-bit code: n=01, d=10, q=11
    a_code      = {a_bits[2] | a_bits[1], a_bits[2] | a_bits[0]};
    b_code      = {b_bits[2] | b_bits[1], b_bits[2] | b_bits[0]};
    first_code  = 2'b00;
    second_code = 2'b00;
    if (a_valid && b_valid) begin
      first_code  = (pri == PRI_A) ? a_code : b_code;
      second_code = (pri == PRI_A) ? b_code : a_code;
    end else if (a_valid) begin
      first_code  = a_code;
    end else if (b_valid) begin
      first_code  = b_code;
    end
    n_valid     = 2'(a_valid) + 2'(b_valid);
    // Space is taken before this cycle's pop; a same-cycle pop frees nothing.
    space       = LW'(DEPTH) - level;
    wr0         = (n_valid != 2'd0) && (space != '0);
    wr1         = (n_valid == 2'd2) && (space > LW'(1));
    n_drop      = 2'(a_bad) + 2'(b_bad) + n_valid - 2'(wr0) - 2'(wr1);
    wr_ptr_nxt  = wr_ptr + PW'(1);
    head        = mem[rd_ptr];
    pop         = (level != '0) && !(out_n | out_d | out_q) && !bus.vend_busy;
  end

  // FIFO storage; contents are don't-care after reset since the level is cleared.
  always_ff @(posedge clk) begin
    if (wr0) mem[wr_ptr] <= first_code;
    if (wr1) mem[wr_ptr_nxt] <= second_code;
  end

  // Pointers, level, priority flag, registered coin outputs and drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      pri    <= PRI_A;
      out_n  <= 1'b0;
      out_d  <= 1'b0;
      out_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr0) + PW'(wr1);
      rd_ptr <= rd_ptr + PW'(pop);
      level  <= level + LW'(wr0) + LW'(wr1) - LW'(pop);
      if (a_valid && b_valid) pri <= (pri == PRI_A) ? PRI_B : PRI_A;
      out_n  <= pop && (head == 2'b01);
      out_d  <= pop && (head == 2'b10);
      out_q  <= pop && (head == 2'b11);
      drop_q <= (n_drop != 2'd0);
    end
  end

  assign bus.nickel     = out_n;
  assign bus.dime       = out_d;
  assign bus.quarter    = out_q;
  assign bus.fifo_level = level;
  assign bus.fifo_full  = (level == LW'(DEPTH));
  assign bus.coin_drop  = drop_q;

`ifdef COIN_SCHED_STATS_EN
  logic [CNT_W-1:0] soda_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W:0]   drop_sum;

  assign drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(n_drop);

  // Saturating vend-cycle and dropped-coin counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      soda_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (bus.vend_busy && (soda_cnt != '1)) soda_cnt <= soda_cnt + 1'b1;
      drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

  assign bus.soda_count = soda_cnt;
  assign bus.drop_count = drop_cnt;
`endif
endmodule
